// File: rtl/mips_pipeline_core.sv
// 5-stage MIPS integer pipeline (IF/ID/EX/MEM/WB) with register file, ALU and hazard logic.
// Define MIPS_FORWARDING_EN for EX operand forwarding; otherwise ID stalls on RAW hazards.
module mips_pipeline_core #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  output logic            dmem_re,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            halted
);
  localparam int         RW    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] RMASK = 5'(NREGS - 1);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_imm;
    logic    halt;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifid_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dst;
  } idex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            halt;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] st;
    logic [4:0]      dst;
  } exmem_t;

  typedef struct packed {
    logic            reg_write;
    logic            halt;
    logic [XLEN-1:0] data;
    logic [4:0]      dst;
  } memwb_t;

  logic [XLEN-1:0] r_pc;
  ifid_t           r_ifid;
  idex_t           r_idex;
  exmem_t          r_exmem;
  memwb_t          r_memwb;
  logic            r_fetch_stop;
  logic            r_halted;
  logic [XLEN-1:0] r_regs [NREGS];

  logic [5:0]      w_op, w_fn;
  logic [4:0]      w_rs, w_rt, w_rd, w_dst;
  logic [XLEN-1:0] w_imm, w_rs_val, w_rt_val;
  ctrl_t           w_ctrl;
  logic            w_use_rs, w_use_rt, w_wb_we, w_stall, w_fetch_hold;
  logic [XLEN-1:0] w_opa, w_opb, w_b, w_alu, w_target;
  logic            w_taken;
  logic            w_unused;

  assign w_op  = r_ifid.instr[31:26];
  assign w_fn  = r_ifid.instr[5:0];
  assign w_rs  = r_ifid.instr[25:21] & RMASK;
  assign w_rt  = r_ifid.instr[20:16] & RMASK;
  assign w_rd  = r_ifid.instr[15:11] & RMASK;
  assign w_imm = {{(XLEN-16){r_ifid.instr[15]}}, r_ifid.instr[15:0]};

  always_comb begin
    w_ctrl   = '0;
    w_dst    = '0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    case (w_op)
      6'h00: begin
        w_ctrl.reg_write = 1'b1;
        w_dst            = w_rd;
        w_use_rs         = 1'b1;
        w_use_rt         = 1'b1;
        case (w_fn)
          6'h20:   w_ctrl.alu_op = ALU_ADD;
          6'h22:   w_ctrl.alu_op = ALU_SUB;
          6'h24:   w_ctrl.alu_op = ALU_AND;
          6'h25:   w_ctrl.alu_op = ALU_OR;
          6'h2A:   w_ctrl.alu_op = ALU_SLT;
          default: begin
            w_ctrl.reg_write = 1'b0;
            w_dst            = '0;
            w_use_rs         = 1'b0;
            w_use_rt         = 1'b0;
          end
        endcase
      end
      6'h23: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_imm   = 1'b1;
        w_dst            = w_rt;
        w_use_rs         = 1'b1;
      end
      6'h2B: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_imm   = 1'b1;
        w_use_rs         = 1'b1;
        w_use_rt         = 1'b1;
      end
      6'h04: begin
        w_ctrl.branch = 1'b1;
        w_use_rs      = 1'b1;
        w_use_rt      = 1'b1;
      end
      6'h08: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_imm   = 1'b1;
        w_dst            = w_rt;
        w_use_rs         = 1'b1;
      end
      6'h3F:   w_ctrl.halt = 1'b1;
      default: ;
    endcase
  end

  // Write-through read: the value WB is committing this cycle is visible to ID.
  assign w_wb_we = r_memwb.reg_write && (r_memwb.dst != 5'd0);

  always_comb begin
    w_rs_val = r_regs[w_rs[RW-1:0]];
    w_rt_val = r_regs[w_rt[RW-1:0]];
    if (w_rs == 5'd0)                           w_rs_val = '0;
    else if (w_wb_we && r_memwb.dst == w_rs)    w_rs_val = r_memwb.data;
    if (w_rt == 5'd0)                           w_rt_val = '0;
    else if (w_wb_we && r_memwb.dst == w_rt)    w_rt_val = r_memwb.data;
  end

`ifdef MIPS_FORWARDING_EN
  logic w_fwd_mem;
  assign w_fwd_mem = r_exmem.reg_write && !r_exmem.mem_read && (r_exmem.dst != 5'd0);
  assign w_stall   = r_idex.ctrl.mem_read && (r_idex.dst != 5'd0) &&
                     ((w_use_rs && w_rs == r_idex.dst) || (w_use_rt && w_rt == r_idex.dst));

  always_comb begin
    w_opa = r_idex.rs_val;
    w_opb = r_idex.rt_val;
    if (w_fwd_mem && r_exmem.dst == r_idex.rs)    w_opa = r_exmem.alu;
    else if (w_wb_we && r_memwb.dst == r_idex.rs) w_opa = r_memwb.data;
    if (w_fwd_mem && r_exmem.dst == r_idex.rt)    w_opb = r_exmem.alu;
    else if (w_wb_we && r_memwb.dst == r_idex.rt) w_opb = r_memwb.data;
  end

  assign w_unused = &{1'b0, r_ifid.instr[10:6]};
`else
  logic w_hz_ex, w_hz_mem;
  // Any in-flight producer in EX or MEM blocks ID; WB is covered by write-through.
  assign w_hz_ex  = r_idex.ctrl.reg_write && (r_idex.dst != 5'd0) &&
                    ((w_use_rs && w_rs == r_idex.dst) || (w_use_rt && w_rt == r_idex.dst));
  assign w_hz_mem = r_exmem.reg_write && (r_exmem.dst != 5'd0) &&
                    ((w_use_rs && w_rs == r_exmem.dst) || (w_use_rt && w_rt == r_exmem.dst));
  assign w_stall  = w_hz_ex || w_hz_mem;
  assign w_opa    = r_idex.rs_val;
  assign w_opb    = r_idex.rt_val;
  assign w_unused = &{1'b0, r_ifid.instr[10:6], r_idex.rs, r_idex.rt};
`endif

  always_comb begin
    w_b   = r_idex.ctrl.alu_imm ? r_idex.imm : w_opb;
    w_alu = w_opa + w_b;
    case (r_idex.ctrl.alu_op)
      ALU_SUB: w_alu = w_opa - w_b;
      ALU_AND: w_alu = w_opa & w_b;
      ALU_OR:  w_alu = w_opa | w_b;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, $signed(w_opa) < $signed(w_b)};
      default: w_alu = w_opa + w_b;
    endcase
  end

  assign w_taken      = r_idex.ctrl.branch && (w_opa == w_opb);
  assign w_target     = r_idex.pc + XLEN'(4) + (r_idex.imm << 2);
  assign w_fetch_hold = r_fetch_stop || w_ctrl.halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ifid       <= '0;
      r_idex       <= '0;
      r_exmem      <= '0;
      r_memwb      <= '0;
      r_fetch_stop <= 1'b0;
      r_halted     <= 1'b0;
    end else if (run) begin
      // A taken branch wins over both a stall and a halt sitting in its shadow.
      if (w_taken)                          r_pc <= w_target;
      else if (!(w_stall || w_fetch_hold))  r_pc <= r_pc + XLEN'(4);

      if (w_taken || (!w_stall && w_fetch_hold)) r_ifid <= '0;
      else if (!w_stall)                         r_ifid <= '{pc: r_pc, instr: imem_rdata};

      if (w_taken || w_stall) r_idex <= '0;
      else r_idex <= '{ctrl: w_ctrl, pc: r_ifid.pc, rs_val: w_rs_val, rt_val: w_rt_val,
                       imm: w_imm, rs: w_rs, rt: w_rt, dst: w_dst};

      r_exmem <= '{reg_write: r_idex.ctrl.reg_write, mem_read: r_idex.ctrl.mem_read,
                   mem_write: r_idex.ctrl.mem_write, halt: r_idex.ctrl.halt,
                   alu: w_alu, st: w_opb, dst: r_idex.dst};

      r_memwb <= '{reg_write: r_exmem.reg_write, halt: r_exmem.halt,
                   data: r_exmem.mem_read ? dmem_rdata : r_exmem.alu, dst: r_exmem.dst};

      r_fetch_stop <= r_fetch_stop || (w_ctrl.halt && !w_taken);
      r_halted     <= r_halted || r_memwb.halt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (run && w_wb_we) begin
      r_regs[r_memwb.dst[RW-1:0]] <= r_memwb.data;
    end
  end

  assign imem_addr    = r_pc;
  assign dmem_addr    = r_exmem.alu;
  assign dmem_wdata   = r_exmem.st;
  assign dmem_we      = run && r_exmem.mem_write;
  assign dmem_re      = run && r_exmem.mem_read;
  assign retire_valid = w_wb_we;
  assign retire_rd    = r_memwb.dst;
  assign retire_data  = r_memwb.data;
  assign halted       = r_halted;
endmodule

// File: tb/tb_mips_pipeline_core.sv
// Directed bench for mips_pipeline_core: small programs, retire log and cycle counts.
module tb_mips_pipeline_core;
`ifdef MIPS_FORWARDING_EN
  localparam int P1_HALT = 8,  P2_HALT = 10, LW_GAP = 2, FRZ_TICKS = 4, RST_TICKS = 5;
  localparam logic        FRZ_RV   = 1'b1;
  localparam logic [4:0]  FRZ_RD   = 5'd1;
  localparam logic [31:0] FRZ_DATA = 32'h1234;
`else
  localparam int P1_HALT = 12, P2_HALT = 13, LW_GAP = 3, FRZ_TICKS = 6, RST_TICKS = 7;
  localparam logic        FRZ_RV   = 1'b0;
  localparam logic [4:0]  FRZ_RD   = 5'd0;
  localparam logic [31:0] FRZ_DATA = 32'h0;
`endif
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clk, rst_n, run;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, retire_data;
  logic        dmem_we, dmem_re, retire_valid, halted;
  logic [4:0]  retire_rd;

  logic [63:0] imem_addr64, dmem_addr64, dmem_wdata64, retire_data64;
  logic        dmem_we64, dmem_re64, retire_valid64, halted64;
  logic [4:0]  retire_rd64;
  logic [31:0] imem_rdata64;

  logic [31:0] imem [64];
  logic [31:0] imem64 [8];
  logic [31:0] dmem [16];

  mips_pipeline_core u_dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data),
    .halted(halted)
  );

  mips_pipeline_core #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_addr(imem_addr64), .imem_rdata(imem_rdata64),
    .dmem_addr(dmem_addr64), .dmem_wdata(dmem_wdata64), .dmem_we(dmem_we64), .dmem_re(dmem_re64),
    .dmem_rdata(64'h0),
    .retire_valid(retire_valid64), .retire_rd(retire_rd64), .retire_data(retire_data64),
    .halted(halted64)
  );

  assign imem_rdata   = (imem_addr < 32'd256) ? imem[imem_addr[7:2]] : 32'h0;
  assign imem_rdata64 = (imem_addr64 < 64'd32) ? imem64[imem_addr64[4:2]] : 32'h0;
  assign dmem_rdata   = dmem[dmem_addr[5:2]];

  always @(posedge clk) if (dmem_we) dmem[dmem_addr[5:2]] <= dmem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } ret_t;

  ret_t        rq[$];
  int          total = 0, bad = 0, cyc = 0, halt_cyc = -1, r64_n = 0;
  logic [4:0]  r64_rd;
  logic [63:0] r64_data;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input int idx, input logic [4:0] rd,
                         input logic [31:0] data);
    if (idx < rq.size()) begin
      chk({tag, "_rd"}, 64'(rq[idx].rd), 64'(rd));
      chk({tag, "_data"}, 64'(rq[idx].data), 64'(data));
    end
  endtask

  // One clock: log retires at the falling edge, advance the cycle count after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n && run && retire_valid) rq.push_back('{retire_rd, retire_data, cyc});
    if (rst_n && run && retire_valid64) begin
      r64_n++;
      r64_rd   = retire_rd64;
      r64_data = retire_data64;
    end
    @(posedge clk);
    #1;
    if (run) begin
      cyc++;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
    end
  endtask

  task automatic release_rst();
    rst_n    = 1'b1;
    cyc      = 0;
    halt_cyc = -1;
    r64_n    = 0;
    rq.delete();
    run      = 1'b1;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    release_rst();
  endtask

  task automatic run_to_halt(input string tag);
    int n = 0;
    while (!halted && n < 80) begin
      tick();
      n++;
    end
    chk({tag, "_halt_reached"}, 64'(halted), 64'd1);
    repeat (2) tick();
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic load_prog2();
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd1, 16'h1234);
    imem[1] = itype(6'h2B, 5'd0, 5'd1, 16'h0000);
    imem[2] = itype(6'h23, 5'd0, 5'd4, 16'h0000);
    imem[3] = rtype(6'h20, 5'd5, 5'd4, 5'd4);
    imem[4] = HALT;
  endtask

  task automatic check_prog2(input string tag);
    chk({tag, "_count"}, 64'(rq.size()), 64'd3);
    chk_ret({tag, "_r0"}, 0, 5'd1, 32'h1234);
    chk_ret({tag, "_r1"}, 1, 5'd4, 32'h1234);
    chk_ret({tag, "_r2"}, 2, 5'd5, 32'h2468);
    chk({tag, "_halt_cyc"}, 64'(halt_cyc), 64'(P2_HALT));
    chk({tag, "_dmem0"}, 64'(dmem[0]), 64'h1234);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) imem64[i] = 32'h0;
    imem64[0] = itype(6'h08, 5'd0, 5'd1, 16'hFFFF);
    imem64[1] = HALT;
    clear_imem();
    run   = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_imem_addr", 64'(imem_addr), 64'h0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retire_valid", 64'(retire_valid), 64'd0);
    chk("rst_dmem_we", 64'(dmem_we), 64'd0);
    chk("rst_dmem_re", 64'(dmem_re), 64'd0);

    // Dependent addi chain.
    imem[0] = itype(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = itype(6'h08, 5'd1, 5'd2, 16'd3);
    imem[2] = rtype(6'h20, 5'd3, 5'd1, 5'd2);
    imem[3] = HALT;
    do_reset();
    run_to_halt("p1");
    chk("p1_count", 64'(rq.size()), 64'd3);
    chk_ret("p1_r0", 0, 5'd1, 32'd5);
    chk_ret("p1_r1", 1, 5'd2, 32'd8);
    chk_ret("p1_r2", 2, 5'd3, 32'd13);
    chk("p1_halt_cyc", 64'(halt_cyc), 64'(P1_HALT));

    // Store, load, load-use.
    load_prog2();
    do_reset();
    run_to_halt("p2");
    check_prog2("p2");
    if (rq.size() == 3) chk("p2_lw_add_gap", 64'(rq[2].cyc - rq[1].cyc), 64'(LW_GAP));

    // Taken branch flushes two addi; a not-taken branch uses a forwarded/stalled operand.
    clear_imem();
    imem[0] = itype(6'h04, 5'd0, 5'd0, 16'd2);
    imem[1] = itype(6'h08, 5'd0, 5'd7, 16'd1);
    imem[2] = itype(6'h08, 5'd0, 5'd8, 16'd2);
    imem[3] = itype(6'h08, 5'd0, 5'd9, 16'd3);
    imem[4] = itype(6'h04, 5'd9, 5'd0, 16'd1);
    imem[5] = itype(6'h08, 5'd0, 5'd10, 16'd4);
    imem[6] = HALT;
    do_reset();
    repeat (3) tick();
    chk("br_resume_pc", 64'(imem_addr), 64'd12);
    run_to_halt("br");
    chk("br_count", 64'(rq.size()), 64'd2);
    chk_ret("br_r0", 0, 5'd9, 32'd3);
    chk_ret("br_r1", 1, 5'd10, 32'd4);
    if (rq.size() > 0) chk("br_r0_cyc", 64'(rq[0].cyc), 64'd7);

    // Freeze with run=0 while the store sits in MEM.
    load_prog2();
    do_reset();
    repeat (FRZ_TICKS) tick();
    chk("frz_we_before", 64'(dmem_we), 64'd1);
    run = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("frz_dmem_we", 64'(dmem_we), 64'd0);
      chk("frz_imem_addr", 64'(imem_addr), 64'd16);
      chk("frz_retire_valid", 64'(retire_valid), 64'(FRZ_RV));
      chk("frz_retire_rd", 64'(retire_rd), 64'(FRZ_RD));
      chk("frz_retire_data", 64'(retire_data), 64'(FRZ_DATA));
      tick();
    end
    run = 1'b1;
    run_to_halt("frz");
    check_prog2("frz");

    // Asynchronous reset between edges while a load is in MEM.
    do_reset();
    repeat (RST_TICKS) tick();
    chk("arst_re_before", 64'(dmem_re), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_imem_addr", 64'(imem_addr), 64'h0);
    chk("arst_dmem_re", 64'(dmem_re), 64'd0);
    chk("arst_dmem_we", 64'(dmem_we), 64'd0);
    chk("arst_retire_valid", 64'(retire_valid), 64'd0);
    chk("arst_halted", 64'(halted), 64'd0);
    @(posedge clk);
    #1;
    release_rst();
    run_to_halt("arst");
    check_prog2("arst");

    // Register 0 is immutable; the 64-bit core runs its own sign-extension program alongside.
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd0, 16'd7);
    imem[1] = rtype(6'h20, 5'd6, 5'd0, 5'd0);
    imem[2] = HALT;
    do_reset();
    run_to_halt("r0");
    chk("r0_count", 64'(rq.size()), 64'd1);
    chk_ret("r0_r0", 0, 5'd6, 32'd0);
    chk("x64_count", 64'(r64_n), 64'd1);
    chk("x64_rd", 64'(r64_rd), 64'd1);
    chk("x64_data", r64_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("x64_halted", 64'(halted64), 64'd1);

    // Remaining ALU operations.
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd1, 16'hFFFD);
    imem[1] = itype(6'h08, 5'd0, 5'd2, 16'd5);
    imem[2] = rtype(6'h22, 5'd3, 5'd2, 5'd1);
    imem[3] = rtype(6'h24, 5'd4, 5'd1, 5'd2);
    imem[4] = rtype(6'h25, 5'd5, 5'd1, 5'd2);
    imem[5] = rtype(6'h2A, 5'd6, 5'd1, 5'd2);
    imem[6] = rtype(6'h2A, 5'd7, 5'd2, 5'd1);
    imem[7] = HALT;
    do_reset();
    run_to_halt("alu");
    chk("alu_count", 64'(rq.size()), 64'd7);
    chk_ret("alu_sub", 2, 5'd3, 32'd8);
    chk_ret("alu_and", 3, 5'd4, 32'd5);
    chk_ret("alu_or", 4, 5'd5, 32'hFFFF_FFFD);
    chk_ret("alu_slt1", 5, 5'd6, 32'd1);
    chk_ret("alu_slt0", 6, 5'd7, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_pipeline_core.md
Name: mips_pipeline_core

Overview:
- Parametrised 5-stage MIPS integer pipeline (IF/ID/EX/MEM/WB) with an internal register file and ALU.
- Instruction and data memories sit outside the core; it drives their address/control ports and reads them combinationally.
- Added hazard handling: operand forwarding, load-use interlock, branch flush, halt detection and a `run` gate that freezes the pipeline while memories are being loaded.
- Sits at the top of the CPU, between the loaders/memories and the testbench.

Parameters:
- XLEN, 32, datapath/register/PC width; 32 or 64. Instructions are always 32 bits.
- NREGS, 32, architectural registers; power of 2, at most 32. Register fields index modulo NREGS.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = pipeline advances; 0 = all state frozen (loading)
- imem_addr  out  XLEN  PC of fetched instruction (byte address)
- imem_rdata  in  32  instruction at imem_addr, same cycle
- dmem_addr  out  XLEN  MEM-stage ALU result
- dmem_wdata  out  XLEN  MEM-stage store data
- dmem_we  out  1  store strobe, MEM stage
- dmem_re  out  1  load strobe, MEM stage
- dmem_rdata  in  XLEN  load data, same cycle
- retire_valid  out  1  WB stage writes a register this cycle
- retire_rd  out  5  destination register of the retiring instruction
- retire_data  out  XLEN  value being written
- halted  out  1  sticky; halt instruction has reached WB

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; every pipeline register is a bubble (all control bits 0); registers 0..NREGS-1 = 0.
  - halted=0, retire_valid=0, dmem_we=0, dmem_re=0.
- Stall, flush and halt all apply only when run=1. run=0 holds every register, including the PC; dmem_we and dmem_re are forced to 0.
- Instruction set:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed). Any other funct is a NOP.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, halt 0x3F.
  - Any other opcode is a NOP.
- Immediates are sign-extended from bit 15 to XLEN.
- Branch target = (PC+4) + (sext(imm) << 2), computed in EX.
- Register file:
  - Register 0 reads 0 and ignores writes.
  - WB writes on the rising edge. A same-cycle read of the register being written returns the new value (write-through).
- Forwarding to EX operands, priority order:
  1. EX/MEM (non-load, RegWrite, rd≠0)
  2. MEM/WB (RegWrite, rd≠0)
  3. register value latched at ID
- Load-use interlock:
  - Condition: ID needs rs, or rt (R-type/beq/sw), and EX holds a lw whose rt equals that register (≠0).
  - Action: hold PC and IF/ID, insert a bubble into ID/EX. Penalty is exactly 1 cycle.
- Branch:
  - beq is taken when EX operands are equal (after forwarding).
  - On the next edge: PC←target, IF/ID and ID/EX become bubbles. Penalty is 2 cycles.
  - A taken branch overrides a simultaneous load-use stall.
- Halt:
  - When halt decodes in ID, fetch stops: PC holds and IF/ID receives bubbles.
  - Older instructions drain.
  - When halt reaches WB, halted=1 until reset. It has no register or memory effect.
  - A halt in a branch shadow is flushed like any other instruction.
- PC arithmetic wraps modulo 2^XLEN.
- Retire outputs are driven from MEM/WB combinationally. retire_valid=RegWrite && rd≠0.

Optional Feature:
- Macro: MIPS_FORWARDING_EN.
- Defined: forwarding and the 1-cycle load-use interlock, as above.
- Undefined:
  - No forwarding paths.
  - ID stalls, with PC and IF/ID held and an ID/EX bubble, while either source (≠0) matches a RegWrite destination in EX or MEM.
  - The WB case is covered by write-through, so a dependent instruction immediately behind its producer costs 2 stall cycles.
- Architectural results are identical either way; only cycle counts differ.

Test Plan:
- Reset then run=1, program `addi $1,$0,5; addi $2,$1,3; add $3,$1,$2; halt`:
  - Forwarding defined: retire ($1,5), ($2,8), ($3,13); halted rises 8 cycles after the first fetch.
  - Forwarding undefined: same retire values; halted rises 4 cycles later.
- `sw $1,0($0)` with $1=0x1234, then `lw $4,0($0); add $5,$4,$4`: exactly one bubble between lw and add in EX; $5=0x2468.
- `beq $0,$0,+2` followed by two `addi` instructions: neither addi retires; fetch resumes at branch_PC+12; exactly 2 bubbles.
- run dropped to 0 mid-program for 10 cycles: imem_addr and all retire outputs are unchanged, dmem_we=0; after run returns to 1, results match the uninterrupted run.
- rst_n asserted mid-program (asynchronously, between edges): all outputs immediately return to their reset values; execution restarts at RESET_PC.
- `addi $0,$0,7` followed by `add $6,$0,$0`: retire_valid stays 0 for the first; $6=0. Repeat with XLEN=64: `addi $1,$0,-1` gives 0xFFFF_FFFF_FFFF_FFFF.
